// File: rtl/fs_pkg.sv
// rtl/fs_pkg.sv - shared types and sizing helpers for the bit-serial subtractor
package fs_pkg;

  localparam int FS_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ceil(log2(n)), never less than 1 so a counter always has at least one bit
  function automatic int CNT_W(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fs_bit.sv
// rtl/fs_bit.sv - combinational full-subtractor cell
// Ports: a, b  operand bits (a - b)
//        bi    borrow in
//        d     difference bit
//        bo    borrow out
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  // Borrow when b exceeds a outright, or when they tie and a borrow is pending.
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/fs_serial.sv
// rtl/fs_serial.sv - bit-serial A - B - bin, LSB first, with parallel result
// Ports: ck           clock, rising edge
//        rst_n        asynchronous active-low reset
//        start, bin   request and initial borrow, taken only in IDLE
//        a_bit, b_bit serial operand bits, sampled each RUN cycle
//        d            registered difference bit of the last sampled pair
//        diff, bout   parallel difference and final borrow, held after DONE
//        busy, done   RUN indicator and single-cycle completion pulse
module fs_serial
  import fs_pkg::*;
#(
  parameter int W = FS_W_DEFAULT
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         start,
  input  logic         bin,
  input  logic         a_bit,
  input  logic         b_bit,
  output logic         d,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  localparam int CW = CNT_W(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d;
  logic          d_q, d_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;

  logic cell_d, cell_bo;

  fs_bit u_bit (
    .a  (a_bit),
    .b  (b_bit),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    d_d     = d_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          br_d    = bin;
        end
      end
      ST_RUN: begin
        d_d    = cell_d;
        br_d   = cell_bo;
        // New bits enter at the top so bit 0 lands at diff[0] after W shifts.
        diff_d = {cell_d, diff_q[W-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          // Captured here so bout is already valid in the DONE cycle and
          // then holds through IDLE alongside diff.
          bout_d  = cell_bo;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      d_q     <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      d_q     <= d_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign d    = d_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_fs_serial.sv
// tb/tb_fs_serial.sv - scoreboard bench for fs_serial (W=8 and W=2 instances)
module tb_fs_serial;

  localparam int W  = 8;
  localparam int W2 = 2;

  logic         ck = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, bin = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
  logic         d, bout, busy, done;
  logic [W-1:0] diff;

  logic          start2 = 1'b0, bin2 = 1'b0, a2 = 1'b0, b2 = 1'b0;
  logic          d2, bout2, busy2, done2;
  logic [W2-1:0] diff2;

  fs_serial #(.W(W)) dut (
    .ck(ck), .rst_n(rst_n), .start(start), .bin(bin), .a_bit(a_bit), .b_bit(b_bit),
    .d(d), .diff(diff), .bout(bout), .busy(busy), .done(done)
  );

  fs_serial #(.W(W2)) dut2 (
    .ck(ck), .rst_n(rst_n), .start(start2), .bin(bin2), .a_bit(a2), .b_bit(b2),
    .d(d2), .diff(diff2), .bout(bout2), .busy(busy2), .done(done2)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    int         start_cyc;
    bit         chk_gap;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   last_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge ck);
    cyc = cyc + 1;
  end

  // Monitor for the W=8 instance
  initial forever begin
    exp_t e;
    @(negedge ck);
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("diff", 32'(diff), 32'(e.diff));
        chk("bout", 32'(bout), 32'(e.bout));
        chk("done_latency", 32'(cyc - e.start_cyc), 32'(W + 1));
        if (e.chk_gap) chk("done_gap", 32'(cyc - last_done), 32'(W + 2));
      end
      last_done = cyc;
    end
  end

  // Monitor for the W=2 instance
  initial forever begin
    exp_t e;
    @(negedge ck);
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        chk("diff_w2", 32'(diff2), 32'(e.diff[W2-1:0]));
        chk("bout_w2", 32'(bout2), 32'(e.bout));
        chk("done_latency_w2", 32'(cyc - e.start_cyc), 32'(W2 + 1));
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || done) && t < 50) begin
      @(posedge ck);
      #1;
      t++;
    end
    if (t == 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Drives W bit pairs after an accepting edge; returns 1 if aborted by reset.
  task automatic feed_bits(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_diff, input int abort_at,
                           output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < W; i++) begin
      a_bit = a[i];
      b_bit = b[i];
      @(posedge ck);
      #1;
      chk("d_bit", 32'(d), 32'(exp_diff[i]));
      if (i == 0) chk("busy_run", 32'(busy), 32'd1);
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge ck);
        #1;
        aborted = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] exp_diff, input logic exp_bout,
                        input int abort_at);
    bit ab;
    wait_idle();
    start = 1'b1;
    bin   = bi;
    q.push_back('{exp_diff, exp_bout, cyc, 1'b0});
    @(posedge ck);
    #1;
    start = 1'b0;
    bin   = 1'b0;
    feed_bits(a, b, exp_diff, abort_at, ab);
    if (ab) void'(q.pop_back());
  endtask

  initial begin
    bit ab;
    logic [1:0] a2v, b2v;
    int t;

    #3;
    chk("reset_d", 32'(d), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_bout", 32'(bout), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge ck);
    #1;

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, -1);
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, -1);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, -1);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1);
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, -1);
    run_op(8'hC8, 8'h37, 1'b1, 8'h90, 1'b0, -1);

    // start held high: back-to-back operations, pulses during RUN/DONE ignored
    wait_idle();
    start = 1'b1;
    for (int op = 0; op < 3; op++) begin
      q.push_back('{8'h4B, 1'b0, cyc, op > 0});
      @(posedge ck);
      #1;
      feed_bits(8'hA5, 8'h5A, 8'h4B, -1, ab);
      @(posedge ck);
      #1;
    end
    start = 1'b0;

    // reset mid-operation after bit 4, then a fresh operation
    run_op(8'h11, 8'h22, 1'b0, 8'hEF, 1'b1, 4);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, -1);

    // W=2: 2 - 3 = 3 mod 4 with borrow
    a2v = 2'b10;
    b2v = 2'b11;
    start2 = 1'b1;
    q2.push_back('{8'd3, 1'b1, cyc, 1'b0});
    @(posedge ck);
    #1;
    start2 = 1'b0;
    for (int i = 0; i < W2; i++) begin
      a2 = a2v[i];
      b2 = b2v[i];
      @(posedge ck);
      #1;
    end

    t = 0;
    while ((q.size() + q2.size()) != 0 && t < 40) begin
      @(posedge ck);
      #1;
      t++;
    end
    chk("queue_drain", 32'(q.size() + q2.size()), 32'd0);
    repeat (3) @(posedge ck);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
